// File: rtl/z1010_flop_pkg.sv
// z1010_flop_pkg: shared types and helpers for the z1010 flop-mode config controller
package z1010_flop_pkg;
   localparam int MODE_W = 4;
   typedef enum logic [MODE_W-1:0] {
      DFF = 4'd0, DFFE, DFFH, DFFL, DFFR, DFFS, DFFEH, DFFEL, DFFER
   } flop_mode_e;
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_RST_HOLD, S_DONE
   } ctrl_state_e;
   function automatic logic mode_legal(input logic [MODE_W-1:0] code);
      return code <= MODE_W'(DFFER);
   endfunction
endpackage

// File: rtl/z1010_flop_cfg_ctrl_serializer.sv
// z1010_cfg_serializer: load/shift register that streams one mode code LSB first
module z1010_cfg_serializer
   import z1010_flop_pkg::*;
(
   input  logic              clk,
   input  logic              nreset,
   input  logic              load_i,
   input  logic [MODE_W-1:0] code_i,
   input  logic              en_i,
   output logic              sdo_o,
   output logic              shift_en_o,
   output logic              last_o
);
   localparam int CNT_W = (MODE_W > 1) ? $clog2(MODE_W) : 1;
   logic [MODE_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;
   // a handshake loads a fresh code; each enabled cycle moves the next bit to sreg[0]
   always_comb begin
      sreg_d = load_i ? code_i : en_i ? sreg_q >> 1 : sreg_q;
      bcnt_d = load_i ? '0 : en_i ? bcnt_q + 1'b1 : bcnt_q;
   end
   // shift register and bit counter
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         sreg_q <= '0;
         bcnt_q <= '0;
      end else begin
         sreg_q <= sreg_d;
         bcnt_q <= bcnt_d;
      end
   assign shift_en_o = en_i;
   assign sdo_o      = en_i & sreg_q[0];
   assign last_o     = en_i && bcnt_q == CNT_W'(MODE_W - 1);
endmodule

// File: rtl/z1010_flop_cfg_ctrl.sv
// z1010_flop_cfg_ctrl: checks per-site flop mode codes and loads them onto the cluster config chain
module z1010_flop_cfg_ctrl
   import z1010_flop_pkg::*;
#(
   parameter int NUM_SITES  = 16,
   parameter int RST_CYCLES = 8,
   parameter int SITE_W     = $clog2(NUM_SITES)
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic              mode_valid,
   input  logic [MODE_W-1:0] mode_code,
   output logic              mode_ready,
   output logic              cfg_sdo,
   output logic              cfg_shift_en,
   output logic              cfg_latch,
   output logic              fab_rst_n,
   output logic              busy,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [SITE_W-1:0] site_idx
);
   localparam int CNT_W = $clog2(RST_CYCLES + 1);
   ctrl_state_e       state_q, state_d;
   logic [SITE_W-1:0] site_q, site_d;
   logic [CNT_W-1:0]  hold_q, hold_d;
   logic              err_q, err_d;
   logic              hs, go, last, last_site;
   assign hs        = mode_valid && mode_ready;
   assign go        = start && (state_q == S_IDLE || state_q == S_DONE);
   assign last_site = site_q == SITE_W'(NUM_SITES - 1);
   z1010_cfg_serializer u_ser (
      .clk       (clk),
      .nreset    (nreset),
      .load_i    (hs),
      .code_i    (mode_legal(mode_code) ? mode_code : MODE_W'(DFF)),
      .en_i      (state_q == S_SHIFT),
      .sdo_o     (cfg_sdo),
      .shift_en_o(cfg_shift_en),
      .last_o    (last)
   );
   // state, site index, reset-hold counter and sticky error
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         state_q <= S_IDLE;
         site_q  <= '0;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         site_q  <= site_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   // sequencing: load, shift each site, latch the chain, then hold the fabric in reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_LOAD;
         S_LOAD:         if (mode_valid) state_d = S_SHIFT;
         S_SHIFT:        if (last) state_d = last_site ? S_LATCH : S_LOAD;
         S_LATCH:        state_d = S_RST_HOLD;
         S_RST_HOLD:     if (hold_q == '0) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
      site_d = go ? '0 : (last && !last_site) ? site_q + 1'b1 : site_q;
      hold_d = state_q == S_LATCH ? CNT_W'(RST_CYCLES - 1) :
               state_q == S_RST_HOLD ? hold_q - 1'b1 : hold_q;
      err_d  = go ? 1'b0 : (hs && !mode_legal(mode_code)) ? 1'b1 : err_q;
   end
   // Moore outputs decoded from the current state
   always_comb begin
      mode_ready = state_q == S_LOAD;
      busy       = !(state_q == S_IDLE || state_q == S_DONE);
      cfg_latch  = state_q == S_LATCH;
      cfg_done   = state_q == S_DONE;
      fab_rst_n  = state_q == S_DONE;
   end
   assign cfg_err  = err_q;
   assign site_idx = site_q;
endmodule

// File: tb/tb_z1010_flop_cfg_ctrl.sv
// tb_z1010_flop_cfg_ctrl: directed/randomized load sequences against a cycle-count and chain-content model
module tb_z1010_flop_cfg_ctrl;
   import z1010_flop_pkg::*;
   localparam int NS = 16;
   localparam int RC = 8;
   localparam int SW = $clog2(NS);
   localparam int SITE_CYC = 1 + MODE_W;
   logic clk = 1'b0, nreset = 1'b1, start = 1'b0, mode_valid = 1'b0;
   logic [MODE_W-1:0] mode_code = '0;
   logic mode_ready, cfg_sdo, cfg_shift_en, cfg_latch, fab_rst_n, busy, cfg_done, cfg_err;
   logic [SW-1:0] site_idx;
   int total = 0, bad = 0;
   int cyc, latch_edge, latch_cnt, done_edge, inv_bad;
   bit err_seen;
   int codes[NS];
   bit bits[$];
   int hs_edge[$], hs_site[$];

   z1010_flop_cfg_ctrl #(.NUM_SITES(NS), .RST_CYCLES(RC)) dut (
      .clk(clk), .nreset(nreset), .start(start), .mode_valid(mode_valid),
      .mode_code(mode_code), .mode_ready(mode_ready), .cfg_sdo(cfg_sdo),
      .cfg_shift_en(cfg_shift_en), .cfg_latch(cfg_latch), .fab_rst_n(fab_rst_n),
      .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .site_idx(site_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ctl"}, {mode_ready, cfg_sdo, cfg_shift_en, cfg_latch, fab_rst_n, busy, cfg_done, cfg_err}, 0);
      chk({tag, "_site"}, site_idx, 0);
   endtask

   // observe what the coming edge will see, then advance one edge
   task automatic step();
      @(negedge clk);
      if (cfg_shift_en) bits.push_back(cfg_sdo);
      if (!cfg_shift_en && cfg_sdo) inv_bad++;
      if (fab_rst_n !== cfg_done) inv_bad++;
      if (mode_ready && !busy) inv_bad++;
      if (mode_ready && cfg_shift_en) inv_bad++;
      if (err_seen && !cfg_err) inv_bad++;
      if (cfg_err) err_seen = 1'b1;
      if (mode_valid && mode_ready) begin
         hs_edge.push_back(cyc);
         hs_site.push_back(int'(site_idx));
      end
      if (cfg_latch) begin
         latch_cnt++;
         latch_edge = cyc;
      end
      if (fab_rst_n && done_edge < 0) done_edge = cyc;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input string name, input int stall_site, input int stall_len,
                      input int bstart_site, input int abort_site);
      int site, stall, guard, any_bad, mism, exp_latch, exp_edge;
      logic [MODE_W-1:0] nib;
      site = 0; stall = stall_len; guard = 0; any_bad = 0; mism = 0;
      bits.delete(); hs_edge.delete(); hs_site.delete();
      latch_cnt = 0; latch_edge = -1; inv_bad = 0; done_edge = -1;
      cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      done_edge = -1;
      err_seen = 1'b0;
      chk({name, "_start_busy"}, busy, 1);
      chk({name, "_start_err"}, cfg_err, 0);
      chk({name, "_start_fab"}, {fab_rst_n, cfg_done}, 0);
      chk({name, "_start_site"}, site_idx, 0);
      while (!cfg_done && guard < 400) begin
         if (abort_site >= 0 && site - 1 == abort_site && cfg_shift_en) begin
            #2 nreset = 1'b0;
            #1;
            chk_reset_vals({name, "_abort"});
            chk({name, "_abort_no_latch"}, latch_cnt, 0);
            mode_valid = 1'b0;
            return;
         end
         start = mode_ready && site == bstart_site;
         if (mode_ready) begin
            if (site == stall_site && stall > 0) begin
               mode_valid = 1'b0;
               stall--;
            end else begin
               mode_valid = 1'b1;
               mode_code = MODE_W'(codes[site]);
               site++;
            end
         end else begin
            mode_valid = 1'($urandom);
            mode_code = MODE_W'($urandom);
         end
         step();
         guard++;
      end
      start = 1'b0;
      mode_valid = 1'b0;
      step();
      chk({name, "_done"}, cfg_done, 1);
      chk({name, "_nbits"}, bits.size(), NS * MODE_W);
      for (int k = 0; k < NS; k++) begin
         for (int j = 0; j < MODE_W; j++) nib[j] = bits[k * MODE_W + j];
         chk($sformatf("%s_site%0d_bits", name, k), nib, codes[k] < 9 ? codes[k] : 0);
         if (codes[k] >= 9) any_bad = 1;
      end
      chk({name, "_nhs"}, hs_edge.size(), NS);
      for (int k = 0; k < NS && k < hs_edge.size(); k++) begin
         exp_edge = 1 + k * SITE_CYC + ((stall_site >= 0 && k >= stall_site) ? stall_len : 0);
         if (hs_edge[k] != exp_edge || hs_site[k] != k) mism++;
      end
      chk({name, "_hs_timing"}, mism, 0);
      exp_latch = NS * SITE_CYC + 1 + stall_len;
      chk({name, "_latch_cnt"}, latch_cnt, 1);
      chk({name, "_latch_edge"}, latch_edge, exp_latch);
      chk({name, "_done_edge"}, done_edge, exp_latch + RC + 1);
      chk({name, "_err"}, cfg_err, any_bad);
      chk({name, "_invariants"}, inv_bad, 0);
   endtask

   initial begin
      #2 nreset = 1'b0;
      #10;
      chk_reset_vals("reset");
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("idle");

      for (int k = 0; k < NS; k++) codes[k] = k % 9;
      run("base", -1, 0, -1, -1);

      for (int k = 0; k < NS; k++) codes[k] = $urandom_range(0, 8);
      codes[3] = 11;
      run("err_stall", 2, 5, 5, -1);
      chk("done_err_held", cfg_err, 1);

      for (int k = 0; k < NS; k++) codes[k] = $urandom_range(0, 15);
      run("rand", -1, 0, -1, -1);

      for (int k = 0; k < NS; k++) codes[k] = $urandom_range(0, 8);
      run("abort", -1, 0, -1, 7);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("abort_hold");
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      run("reload", -1, 0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
